avalon_count_master: RTL
========================

Name: avalon_count_master

Overview:
- Avalon-MM initiator that drives a binary count into a memory-mapped output PIO (seven-segment / LED register) over the system fabric.
- Write-then-readback engine:
  - A prescaler generates a periodic tick.
  - On each tick the master writes the next count value to the PIO data register.
  - It then reads the register back and flags any mismatch.
- Sits beside the Nios-less count_bin datapath as the bus master for the PIO slave.

Parameters:
- TICK_DIV, 50000000, clk cycles per count tick (>=2)
- COUNT_W, 16, width of count value (1..32)
- ADDR_W, 2, Avalon address width
- TARGET_ADDR, 0, word address of the PIO data register
- READBACK, 1, 1 = read back and compare after every write; 0 = write only

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  level; ticks are generated and counted only while high
- avm_address  out  ADDR_W  Avalon address (driven as TARGET_ADDR)
- avm_write  out  1  write request
- avm_read  out  1  read request
- avm_writedata  out  32  zero-extended count value
- avm_readdata  in  32  read data, valid in the cycle read is accepted
- avm_waitrequest  in  1  slave stall; a request is accepted when read/write is high and waitrequest is low
- count_out  out  COUNT_W  last value accepted by the slave
- busy  out  1  high whenever state != IDLE
- mismatch  out  1  sticky readback error
- overrun  out  1  sticky: a tick was lost

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values (asynchronous assert, released on a clk edge):
  - all outputs 0
  - prescaler 0, next_count 0, pending 0, state IDLE
- Prescaler:
  - While enable = 1, counts 0..TICK_DIV-1 and pulses tick for one cycle when it wraps to 0.
  - enable = 0 holds the prescaler at 0; no ticks are generated.
- Pending flag:
  - tick sets pending.
  - Leaving IDLE clears pending.
  - tick while pending = 1 sets overrun; the tick is dropped, not queued.
- FSM states: IDLE, WR, RD, CHK.
- IDLE:
  - If pending = 1, go to WR.
  - Register avm_writedata = {zeros, next_count} and assert avm_write in the same transition, so the write appears on the bus the cycle after the tick.
- WR:
  - Hold address, writedata and write stable while avm_waitrequest = 1. There is no timeout.
  - On acceptance: deassert write, count_out <= next_count, next_count <= next_count + 1 modulo 2^COUNT_W (wraps all-ones -> 0).
  - Then go to RD if READBACK = 1, else IDLE.
- RD:
  - Assert avm_read and hold it while waitrequest = 1.
  - On acceptance, capture avm_readdata, deassert read, go to CHK.
- CHK (one cycle):
  - mismatch <= mismatch | (rdata[COUNT_W-1:0] != count_out) | (|rdata[31:COUNT_W] when COUNT_W < 32).
  - Go to IDLE.
- Bus rules:
  - avm_read and avm_write are never high in the same cycle.
  - No new request is issued until the previous one is accepted.
- Latency: tick -> write on bus = 1 cycle. With zero wait states, a full write/read/check cycle takes 4 cycles from tick back to IDLE.
- Mid-transaction inputs:
  - enable falling mid-transaction does not abort it; the transaction completes.
  - A pending tick still executes after enable falls.
- Reset mid-transaction: read/write drop immediately (asynchronous), all state clears, and the next count restarts at 0.
- Sticky flags mismatch and overrun clear only on reset.

Decomposition:
- Shared package (count_bin_pkg):
  - state enum (IDLE/WR/RD/CHK)
  - default TICK_DIV, COUNT_W, and PIO register offset constants
- One natural sub-module: tick_prescaler (parameter TICK_DIV; ports clk, reset, enable, tick).
- FSM and datapath stay in the top module.

Test Plan:
- Zero-wait slave model, TICK_DIV = 4, enable = 1:
  - Writes of 0, 1, 2, 3 appear 4 cycles apart at address 0, each followed by a read.
  - count_out tracks the written value; mismatch = 0.
- Slave asserts waitrequest for 3 cycles on each write and each read:
  - avm_address, avm_writedata and avm_write are held stable for those cycles; read is held likewise.
  - Exactly one write is accepted per tick.
- COUNT_W = 4, run 17 ticks:
  - Write sequence ...14, 15, 0 (wrap).
  - writedata[31:4] = 0 on every write.
- Slave returns 0x0001_0005 on the readback of count 5:
  - mismatch rises after CHK and stays 1 on later correct reads.
- TICK_DIV = 2 with waitrequest held 6 cycles:
  - overrun = 1.
  - No back-to-back overlapping requests.
  - Counts remain consecutive with no skips.
- Assert reset for 1 cycle while avm_write = 1 and waitrequest = 1:
  - write drops in the same cycle and all outputs read 0.
  - The first write after release carries value 0.

Source files
------------

// File: rtl/avalon_count_master_pkg.sv
// ---------------------------------------------------------------------------
// avalon_count_master_pkg
//   Shared types and defaults for the Avalon-MM count master.
//   - state_e        : master FSM states (IDLE/WR/RD/CHK)
//   - DEF_TICK_DIV   : default clk cycles per count tick
//   - DEF_COUNT_W    : default count width
//   - PIO_DATA_OFFSET: word offset of the PIO data register
//   - AVM_DATA_W     : Avalon data bus width
// ---------------------------------------------------------------------------
package avalon_count_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_CHK  = 2'd3
    } state_e;

    localparam int DEF_TICK_DIV    = 50000000;
    localparam int DEF_COUNT_W     = 16;
    localparam int PIO_DATA_OFFSET = 0;
    localparam int AVM_DATA_W      = 32;

endpackage

// File: rtl/avalon_count_master_if.sv
// ---------------------------------------------------------------------------
// avalon_count_master_if
//   Avalon-MM initiator/target signal bundle.
//   master modport: drives address/read/write/writedata, samples
//                   readdata/waitrequest.
//   slave  modport: the mirror image, for the PIO target or a bench model.
// ---------------------------------------------------------------------------
interface avalon_count_master_if #(
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic              avm_read;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_write,
        output avm_read,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_write,
        input  avm_read,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/avalon_count_master_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//   Free-running divider that emits a one-cycle tick every TICK_DIV clocks
//   while enable is high. enable low parks the counter at 0.
//   Ports:
//     clk    in  system clock
//     reset  in  asynchronous, active-high reset
//     enable in  count enable (level)
//     tick   out one-cycle pulse on the cycle the counter wraps to 0
// ---------------------------------------------------------------------------
module tick_prescaler
    import avalon_count_master_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(TICK_DIV - 1));
    assign tick = enable && wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable)   cnt_d = '0;
        else if (wrap) cnt_d = '0;
        else           cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/avalon_count_master.sv
// ---------------------------------------------------------------------------
// avalon_count_master
//   Avalon-MM initiator that writes an incrementing count to a PIO data
//   register on every prescaler tick and optionally reads it back to verify.
//   Ports:
//     clk       in   system clock
//     reset     in   asynchronous, active-high reset
//     enable    in   tick generation enable (level)
//     avm       if   Avalon-MM master bundle (address/read/write/data/wait)
//     count_out out  last count value accepted by the slave
//     busy      out  FSM not in IDLE
//     mismatch  out  sticky readback error
//     overrun   out  sticky lost-tick flag
// ---------------------------------------------------------------------------
module avalon_count_master
    import avalon_count_master_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int COUNT_W     = DEF_COUNT_W,
    parameter int ADDR_W      = 2,
    parameter int TARGET_ADDR = PIO_DATA_OFFSET,
    parameter bit READBACK    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    avalon_count_master_if.master avm,
    output logic [COUNT_W-1:0]    count_out,
    output logic                  busy,
    output logic                  mismatch,
    output logic                  overrun
);
    state_e               state_q, state_d;
    logic                 pending_q, pending_d;
    logic                 overrun_q, overrun_d;
    logic                 mismatch_q, mismatch_d;
    logic [COUNT_W-1:0]   next_q, next_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 write_q, write_d;
    logic                 read_q, read_d;
    logic                 tick;
    logic                 launch;
    logic                 rdata_bad;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // Readback is wrong if the low bits differ or any bit above the count
    // width is set.
    if (COUNT_W < 32) begin : g_part
        assign rdata_bad = (rdata_q[COUNT_W-1:0] != count_q) || (|rdata_q[31:COUNT_W]);
    end else begin : g_full
        assign rdata_bad = (rdata_q != 32'(count_q));
    end

    // A tick seen in IDLE launches directly so the write reaches the bus
    // one cycle after the tick; pending only remembers ticks that arrive
    // while a transaction is in flight.
    assign launch = (state_q == ST_IDLE) && (pending_q || tick);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        mismatch_d = mismatch_q;
        next_d     = next_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        write_d    = write_q;
        read_d     = read_q;

        // Only one tick can be outstanding; a second one is dropped.
        if (tick && pending_q) overrun_d = 1'b1;
        if (launch)            pending_d = 1'b0;
        else if (tick)         pending_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_WR;
                    write_d = 1'b1;
                    wdata_d = 32'(next_q);
                end
            end
            ST_WR: begin
                if (!avm.avm_waitrequest) begin
                    write_d = 1'b0;
                    count_d = next_q;
                    next_d  = next_q + COUNT_W'(1);
                    if (READBACK) begin
                        state_d = ST_RD;
                        read_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD: begin
                if (!avm.avm_waitrequest) begin
                    read_d  = 1'b0;
                    rdata_d = avm.avm_readdata;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                mismatch_d = mismatch_q | rdata_bad;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            mismatch_q <= 1'b0;
            next_q     <= '0;
            count_q    <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            mismatch_q <= mismatch_d;
            next_q     <= next_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            write_q    <= write_d;
            read_q     <= read_d;
        end
    end

    assign avm.avm_address   = ADDR_W'(TARGET_ADDR);
    assign avm.avm_write     = write_q;
    assign avm.avm_read      = read_q;
    assign avm.avm_writedata = wdata_q;
    assign count_out         = count_q;
    assign busy              = (state_q != ST_IDLE);
    assign mismatch          = mismatch_q;
    assign overrun           = overrun_q;
endmodule
